// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state encoding, port indices and default widths for the data-memory arbiter
package dmem_arb_pkg;
  localparam int DATA_W = 28;
  localparam int ADDR_W = 8;
  localparam int PORT_C = 0;
  localparam int PORT_I = 1;
  typedef enum logic {IDLE, RD_WAIT} state_t;
endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: 2-way round-robin picker; on a tie grants the port not granted last (i_last: 0=C, 1=I)
//   i_req[1:0] in  requests (bit 0 = C, bit 1 = I)
//   i_last     in  port granted most recently
//   o_gnt[1:0] out one-hot grant, zero when nothing requests
module rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_gnt
);
  assign o_gnt = &i_req ? (i_last ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (C) and io/loader (I) ports
//   c_*/i_*  : valid/grant request ports, 1-cycle read return (x_rvalid/x_rdata)
//   cpu_stall: CPU must hold pc_we/reg_we this cycle
//   mem_*    : single-port memory interface, mem_rdata valid one cycle after the address
//   DMEM_ARB_LOCK_EN: adds i_lock; an I grant with i_lock=1 keeps the memory for port I
module dmem_arbiter #(
  parameter int DATA_W = dmem_arb_pkg::DATA_W,
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              i_lock,
`endif
  output logic              cpu_stall,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import dmem_arb_pkg::*;
  state_t      r_state, w_state_nxt;
  logic        r_last, r_owner;
  logic        w_idle, w_rd_wait;
  logic [1:0]  w_req, w_gnt;
  // reset forces every output low in the reset cycle, which also drops an in-flight read
  assign w_idle    = ~rst & (r_state == IDLE);
  assign w_rd_wait = ~rst & (r_state == RD_WAIT);
`ifdef DMEM_ARB_LOCK_EN
  logic r_lock;
  assign w_req = {i_req, c_req & ~r_lock} & {2{w_idle}};
`else
  assign w_req = {i_req, c_req} & {2{w_idle}};
`endif
  rr_pick2 u_pick (
    .i_req (w_req),
    .i_last(r_last),
    .o_gnt (w_gnt)
  );
  always_comb begin
    c_gnt       = w_gnt[PORT_C];
    i_gnt       = w_gnt[PORT_I];
    mem_we      = c_gnt ? c_we : i_gnt & i_we;
    mem_addr    = c_gnt ? c_addr : i_gnt ? i_addr : '0;
    mem_wdata   = c_gnt ? c_wdata : i_gnt ? i_wdata : '0;
    c_rvalid    = w_rd_wait & (r_owner == 1'(PORT_C));
    i_rvalid    = w_rd_wait & (r_owner == 1'(PORT_I));
    c_rdata     = c_rvalid ? mem_rdata : '0;
    i_rdata     = i_rvalid ? mem_rdata : '0;
    cpu_stall   = (c_req & ~c_gnt & ~rst) | c_rvalid;
    w_state_nxt = (|w_gnt & ~mem_we) ? RD_WAIT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'(PORT_I);
      r_owner <= 1'(PORT_C);
    end else begin
      r_state <= w_state_nxt;
      if (|w_gnt) r_last <= w_gnt[PORT_I];
      if (|w_gnt & ~mem_we) r_owner <= w_gnt[PORT_I];
    end
  end
`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) r_lock <= 1'b0;
    else if (i_gnt) r_lock <= i_lock;
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-level arbiter/memory model checked every cycle
module tb_dmem_arbiter;
  localparam int DW = 28;
  localparam int AW = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 0, c_we = 0, i_req = 0, i_we = 0;
  logic [AW-1:0] c_addr = 0, i_addr = 0;
  logic [DW-1:0] c_wdata = 0, i_wdata = 0;
  logic          c_gnt, c_rvalid, i_gnt, i_rvalid, cpu_stall, mem_we;
  logic [DW-1:0] c_rdata, i_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = 0;
  logic [AW-1:0] mem_addr;
`ifdef DMEM_ARB_LOCK_EN
  logic          i_lock = 0;
`endif
  int n_vec = 0;
  int n_bad = 0;
  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .i_lock(i_lock),
`endif
    .cpu_stall(cpu_stall), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] shadow [256];
  initial for (int k = 0; k < 256; k++) begin mem[k] = '0; shadow[k] = '0; end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a pending read (owner/address) blocks grants for one cycle; ties go to the port not served last
  logic          m_pend = 0, m_pown = 0, m_last = 1, m_lock = 0;
  logic [AW-1:0] m_paddr = 0;
  logic          e_cg, e_ig, e_we, e_cv, e_iv, e_st, cand_c, cand_i;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_cr, e_ir;
  always @(negedge clk) begin
    e_cg = 0; e_ig = 0; e_cv = 0; e_iv = 0; e_cr = 0; e_ir = 0;
    if (!rst && m_pend) begin
      e_cv = !m_pown;
      e_iv = m_pown;
      if (e_cv) e_cr = shadow[m_paddr]; else e_ir = shadow[m_paddr];
    end else if (!rst) begin
      cand_c = c_req && !m_lock;
      cand_i = i_req;
      if (cand_c && cand_i) begin e_cg = m_last; e_ig = !m_last; end
      else begin e_cg = cand_c; e_ig = cand_i; end
    end
    e_we   = e_cg ? c_we : (e_ig ? i_we : 1'b0);
    e_addr = e_cg ? c_addr : (e_ig ? i_addr : '0);
    e_wd   = e_cg ? c_wdata : (e_ig ? i_wdata : '0);
    e_st   = !rst && ((c_req && !e_cg) || e_cv);
    chk("c_gnt", c_gnt, e_cg);
    chk("i_gnt", i_gnt, e_ig);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("c_rvalid", c_rvalid, e_cv);
    chk("i_rvalid", i_rvalid, e_iv);
    chk("c_rdata", c_rdata, e_cr);
    chk("i_rdata", i_rdata, e_ir);
    chk("cpu_stall", cpu_stall, e_st);
    if (rst) begin
      m_pend = 0; m_last = 1; m_lock = 0;
    end else if (m_pend) m_pend = 0;
    else if (e_cg || e_ig) begin
      m_last = e_ig;
      if (e_we) shadow[e_addr] = e_wd;
      else begin m_pend = 1; m_pown = e_ig; m_paddr = e_addr; end
`ifdef DMEM_ARB_LOCK_EN
      if (e_ig) m_lock = i_lock;
`endif
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick; rst = 0;
    c_req = 1; c_we = 1; c_addr = 8'h10; c_wdata = 28'h0ABCDEF;
    @(negedge clk);
    chk("t1_c_gnt", c_gnt, 1); chk("t1_mem_we", mem_we, 1);
    chk("t1_mem_addr", mem_addr, 8'h10); chk("t1_stall", cpu_stall, 0);
    tick; c_we = 0;
    @(negedge clk);
    chk("t2_c_gnt", c_gnt, 1); chk("t2_mem_we", mem_we, 0);
    tick; c_req = 0;
    @(negedge clk);
    chk("t2_rvalid", c_rvalid, 1); chk("t2_rdata", c_rdata, 28'h0ABCDEF);
    chk("t2_stall", cpu_stall, 1); chk("t2_no_gnt", c_gnt, 0);
    tick; c_req = 1; c_we = 1; c_addr = 8'h20; c_wdata = 28'h1234567;
    @(negedge clk);
    chk("t2_idle_gnt", c_gnt, 1); chk("t2_rvalid_off", c_rvalid, 0);
    tick; c_req = 0; rst = 1;
    tick; rst = 0;
    c_req = 1; c_we = 1; c_addr = 8'h21; c_wdata = 28'h1111111;
    i_req = 1; i_we = 1; i_addr = 8'h30; i_wdata = 28'h5A5A5A5;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_c_gnt", c_gnt, 32'(k % 2 == 0));
      chk("t3_i_gnt", i_gnt, 32'(k % 2));
      chk("t3_stall", cpu_stall, 32'(k % 2));
      tick;
    end
    i_req = 0;
    @(negedge clk);
    chk("t4_pre_c", c_gnt, 1);
    tick; i_req = 1; i_we = 0; i_addr = 8'h30;
    @(negedge clk);
    chk("t4_i_gnt", i_gnt, 1); chk("t4_c_wait", c_gnt, 0); chk("t4_stall", cpu_stall, 1);
    tick; i_req = 0;
    @(negedge clk);
    chk("t4_rdwait_c", c_gnt, 0); chk("t4_i_rvalid", i_rvalid, 1);
    chk("t4_i_rdata", i_rdata, 28'h5A5A5A5); chk("t4_c_rvalid", c_rvalid, 0);
    tick;
    @(negedge clk);
    chk("t4_c_gnt", c_gnt, 1); chk("t4_i_rvalid_off", i_rvalid, 0);
    tick; c_we = 0; c_addr = 8'h20;
    @(negedge clk);
    chk("t5_c_gnt", c_gnt, 1);
    tick; c_req = 0; rst = 1;
    @(negedge clk);
    chk("t5_rvalid", c_rvalid, 0); chk("t5_rdata", c_rdata, 0);
    chk("t5_stall", cpu_stall, 0); chk("t5_mem_we", mem_we, 0);
    tick; rst = 0;
    c_req = 1; c_we = 1; c_addr = 8'h22; i_req = 1; i_we = 1; i_addr = 8'h31;
    @(negedge clk);
    chk("t5_tie_c", c_gnt, 1); chk("t5_tie_i", i_gnt, 0);
    tick; c_req = 0; i_req = 0;
`ifdef DMEM_ARB_LOCK_EN
    i_req = 1; i_we = 1; i_addr = 8'h40; i_lock = 1;
    @(negedge clk);
    chk("t6_lock_gnt", i_gnt, 1);
    tick; c_req = 1; c_we = 1; c_addr = 8'h41;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6_i_gnt", i_gnt, 1); chk("t6_c_gnt", c_gnt, 0); chk("t6_stall", cpu_stall, 1);
      tick;
    end
    i_lock = 0;
    @(negedge clk);
    chk("t6_unlock_i", i_gnt, 1); chk("t6_unlock_c", c_gnt, 0);
    tick;
    @(negedge clk);
    chk("t6_c_after", c_gnt, 1);
    tick; c_req = 0; i_req = 0;
`endif
    tick; tick;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
